wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back controller for the 16-entry, 16-bit register file. It sits between the execution units and the register-file write port (the rd-indexed write-back demux).
- Arbitrates two result producers, the ALU and the load unit, onto the single write port using valid/ready handshakes.
- Registers the winning write and drives write enable, destination index and data for one cycle.
- Maintains a per-register busy scoreboard that the issue stage reads for hazard stalls.

Parameters:
- DATA_W, 16, result/write data width
- NREG, 16, number of architectural registers (index width = log2(NREG) = 4)
- STARVE_MAX, 3, consecutive ALU losses after which the ALU is forced to win

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  4  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load result available
- ld_ready  out  1  load result accepted this cycle
- ld_rd  in  4  load destination register
- ld_data  in  DATA_W  load result
- iss_valid  in  1  instruction issued with a destination register
- iss_rd  in  4  destination of the issued instruction
- wb_en  out  1  register-file write enable
- wb_rd  out  4  write index (select for the write-back demux)
- wb_data  out  DATA_W  write data
- wb_src  out  2  source of the current write: 0 none, 1 ALU, 2 load
- busy  out  NREG  per-register pending-write bits
- waw_err  out  1  sticky error flag: issue to an already-busy register

Behaviour:
- Reset (asynchronous, active-high): wb_en=0, wb_rd=0, wb_data=0, wb_src=0, busy=0, waw_err=0, starve_cnt=0. A pending grant is dropped.
- The register file always accepts writes, so there is no back-pressure on the wb_* outputs.
- Grant is combinational on the current valids and starve_cnt.
  - ld_valid and not (alu_valid and starve_cnt==STARVE_MAX): grant load.
  - Otherwise, if alu_valid: grant ALU.
  - Exactly one of alu_ready/ld_ready is high when any valid is high; both are 0 when no valid is high.
  - A ready is never asserted without its matching valid.
- Transfer occurs on valid & ready.
- Write latency is 1 cycle. At the edge after a transfer: wb_en=1, wb_rd/wb_data/wb_src take the winning source's values. In a cycle with no transfer, wb_en=0 and wb_rd/wb_data hold their last values.
- starve_cnt (saturating, 0..STARVE_MAX):
  - Increments when alu_valid and the load is granted.
  - Clears when the ALU is granted or alu_valid=0.
  - Never exceeds STARVE_MAX.
- Losing sources must hold valid, rd and data stable until accepted. The block does not buffer a losing request.
- Two sources with the same rd in the same cycle are serialised by the priority rules. The later write overwrites.
- Scoreboard, updated per cycle, per register r:
  - Set when iss_valid and iss_rd==r.
  - Clear when wb_en and wb_rd==r, i.e. the cycle the write is presented.
  - Set and clear in the same cycle for the same r: set wins, so the new issue stays pending.
  - iss_valid to an r with busy[r]=1 and no same-cycle clear: busy stays 1 and waw_err is set. waw_err stays set until reset.
- busy is a registered output and reflects updates one cycle after the causing event.
- The block does not check that a write-back was preceded by an issue. A write to a non-busy register is legal and leaves the bit at 0.

Decomposition:
- Package wb_pkg:
  - DATA_W, NREG, REG_IDX_W=4, STARVE_MAX defaults
  - typedef reg_idx_t (logic [3:0])
  - enum wb_src_e {WB_NONE=0, WB_ALU=1, WB_LD=2}
- Sub-module wb_scoreboard: busy vector and waw_err. Inputs iss_valid, iss_rd, wb_en, wb_rd.
- Top level holds the grant logic, starve_cnt and the output register stage.

Test Plan:
- Reset mid-transfer: ld_valid=1 ld_rd=5 ld_data=0x1234; assert rst in the grant cycle -> next edge wb_en=0, busy=0, no write of r5.
- Single ALU: alu_valid=1 rd=3 data=0xBEEF -> alu_ready=1 same cycle; next cycle wb_en=1 wb_rd=3 wb_data=0xBEEF wb_src=1; following cycle wb_en=0.
- Contention: both valid continuously (ALU rd=1, load rd=2) -> grant order load, load, load, ALU (starve_cnt reaches 3), then load again with starve_cnt=0.
- Same rd: ALU rd=7 data=0x0001 and load rd=7 data=0x0002 both valid -> load writes first, ALU one cycle later; final r7=0x0001.
- Scoreboard set/clear collision: issue rd=4; later, in the cycle wb_en=1 wb_rd=4, issue rd=4 again -> busy[4] stays 1, waw_err=0.
- WAW error: issue rd=9 twice with no write-back between -> busy[9]=1, waw_err=1 and remains 1 after the r9 write-back.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, index/source types and the write request record for the
// register-file write-back path.
package wb_pkg;
  localparam int DATA_W     = 16;
  localparam int NREG       = 16;
  localparam int REG_IDX_W  = 4;
  localparam int STARVE_MAX = 3;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_e;

  typedef struct packed {
    reg_idx_t          rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Producer handshakes, issue notifications and the register-file write port.
// master = execution/issue side, slave = write-back controller.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  reg_idx_t          alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  reg_idx_t          ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              iss_valid;
  reg_idx_t          iss_rd;
  logic              wb_en;
  reg_idx_t          wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        wb_src;
  logic [NREG-1:0]   busy;
  logic              waw_err;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd,
    input  alu_ready, ld_ready, wb_en, wb_rd, wb_data, wb_src, busy, waw_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd,
    output alu_ready, ld_ready, wb_en, wb_rd, wb_data, wb_src, busy, waw_err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write bits plus a sticky flag for issues that land on
// a register that is still waiting for its write-back.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rd,
  input  logic            wb_en,
  input  reg_idx_t        wb_rd,
  output logic [NREG-1:0] busy,
  output logic            waw_err
);
  logic [NREG-1:0] set_v, clr_v, busy_nxt;
  logic            waw_hit;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign set_v[r]    = iss_valid && (iss_rd == reg_idx_t'(r));
    assign clr_v[r]    = wb_en && (wb_rd == reg_idx_t'(r));
    // A new issue in the same cycle as the old write keeps the bit pending.
    assign busy_nxt[r] = set_v[r] | (busy[r] & ~clr_v[r]);
  end

  assign waw_hit = iss_valid && busy[iss_rd] && !clr_v[iss_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      waw_err <= waw_err | waw_hit;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back controller: load-priority arbitration with an ALU anti-starvation
// override, a one-cycle registered write port and the busy scoreboard.
module wb_arbiter
  import wb_pkg::*;
(
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic                alu_win, ld_win, xfer;
  wb_req_t             win_req;
  wb_src_e             win_src;

  logic                wb_en_q;
  wb_req_t             wb_q;
  wb_src_e             wb_src_q;

  // Load wins unless the ALU has already lost STARVE_MAX times in a row.
  assign ld_win  = bus.ld_valid && !(bus.alu_valid && starve_cnt == STARVE_W'(STARVE_MAX));
  assign alu_win = bus.alu_valid && !ld_win;
  assign xfer    = alu_win | ld_win;

  assign bus.alu_ready = alu_win;
  assign bus.ld_ready  = ld_win;

  always_comb begin
    win_req = '0;
    win_src = WB_NONE;
    if (ld_win) begin
      win_req = '{rd: bus.ld_rd, data: bus.ld_data};
      win_src = WB_LD;
    end else if (alu_win) begin
      win_req = '{rd: bus.alu_rd, data: bus.alu_data};
      win_src = WB_ALU;
    end
  end

  always_comb begin
    starve_nxt = '0;
    if (bus.alu_valid && ld_win)
      starve_nxt = (starve_cnt == STARVE_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      wb_en_q    <= 1'b0;
      wb_q       <= '0;
      wb_src_q   <= WB_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      wb_en_q    <= xfer;
      wb_src_q   <= win_src;
      // Index and data hold their last value through idle cycles.
      if (xfer) wb_q <= win_req;
    end
  end

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_rd   = wb_q.rd;
  assign bus.wb_data = wb_q.data;
  assign bus.wb_src  = wb_src_q;

  wb_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wb_en     (wb_en_q),
    .wb_rd     (wb_q.rd),
    .busy      (bus.busy),
    .waw_err   (bus.waw_err)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: expected writes are queued when stimulus is applied
// and compared against the write port one cycle later.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic              en;
    reg_idx_t          rd;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } exp_t;

  exp_t              q[$];
  int                vectors = 0;
  int                miscompares = 0;

  int                st_m;
  logic [NREG-1:0]   busy_m;
  logic              waw_m;
  logic              cur_en;
  reg_idx_t          cur_rd;
  reg_idx_t          last_rd;
  logic [DATA_W-1:0] last_data;
  logic              g_alu, g_ld;
  logic [DATA_W-1:0] dut_rf[NREG];

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic model_reset();
    st_m = 0; busy_m = '0; waw_m = 1'b0; cur_en = 1'b0; cur_rd = '0;
    last_rd = '0; last_data = '0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: check grants, queue the expected write, advance the model,
  // then pop and compare after the edge.
  task automatic step();
    exp_t            e;
    logic            ma, ml;
    logic [NREG-1:0] set_v, clr_v;
    #1;
    ml = bus.ld_valid && !(bus.alu_valid && st_m == STARVE_MAX);
    ma = bus.alu_valid && !ml;
    g_alu = ma; g_ld = ml;
    vectors++;
    if (bus.alu_ready !== ma || bus.ld_ready !== ml) begin
      miscompares++;
      $display("FAIL grant: alu_ready=%b ld_ready=%b, expected %b %b", bus.alu_ready, bus.ld_ready, ma, ml);
    end
    e.en   = ma | ml;
    e.rd   = ml ? bus.ld_rd : (ma ? bus.alu_rd : last_rd);
    e.data = ml ? bus.ld_data : (ma ? bus.alu_data : last_data);
    e.src  = ml ? 2'd2 : (ma ? 2'd1 : 2'd0);
    q.push_back(e);
    st_m = (bus.alu_valid && ml) ? ((st_m < STARVE_MAX) ? st_m + 1 : st_m) : 0;
    set_v = '0; clr_v = '0;
    if (bus.iss_valid) set_v[bus.iss_rd] = 1'b1;
    if (cur_en) clr_v[cur_rd] = 1'b1;
    if (bus.iss_valid && busy_m[bus.iss_rd] && !clr_v[bus.iss_rd]) waw_m = 1'b1;
    busy_m = (busy_m & ~clr_v) | set_v;

    @(posedge clk); #1;
    e = q.pop_front();
    vectors++;
    if (bus.wb_en !== e.en) begin
      miscompares++;
      $display("FAIL wb_en: got %b, expected %b", bus.wb_en, e.en);
    end
    vectors++;
    if (bus.wb_rd !== e.rd || bus.wb_data !== e.data || bus.wb_src !== e.src) begin
      miscompares++;
      $display("FAIL wb_port: rd=%0d data=%h src=%0d, expected rd=%0d data=%h src=%0d",
               bus.wb_rd, bus.wb_data, bus.wb_src, e.rd, e.data, e.src);
    end
    if (bus.wb_en === 1'b1) dut_rf[bus.wb_rd] = bus.wb_data;
    cur_en = e.en; cur_rd = e.rd; last_rd = e.rd; last_data = e.data;
    vectors++;
    if (bus.busy !== busy_m || bus.waw_err !== waw_m) begin
      miscompares++;
      $display("FAIL scoreboard: busy=%h waw_err=%b, expected busy=%h waw_err=%b",
               bus.busy, bus.waw_err, busy_m, waw_m);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.wb_en !== 1'b0 || bus.wb_rd !== 4'd0 || bus.wb_data !== 16'h0 || bus.wb_src !== 2'd0 ||
        bus.busy !== 16'h0 || bus.waw_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: en=%b rd=%0d data=%h src=%0d busy=%h waw=%b, expected all zero",
               bus.wb_en, bus.wb_rd, bus.wb_data, bus.wb_src, bus.busy, bus.waw_err);
    end
    rst = 1'b0;
    model_reset();
    // Reset arrives in the middle of a load grant cycle.
    bus.ld_valid = 1'b1; bus.ld_rd = 4'd5; bus.ld_data = 16'h1234;
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd5;
    #1;
    vectors++;
    if (bus.ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_grant: ld_ready=%b, expected 1", bus.ld_ready);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.wb_en !== 1'b0 || bus.busy !== 16'h0 || bus.wb_rd !== 4'd0 || bus.wb_data !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_midxfer: en=%b busy=%h rd=%0d data=%h, expected 0 0 0 0",
               bus.wb_en, bus.busy, bus.wb_rd, bus.wb_data);
    end
    idle_inputs();
    rst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 16'hBEEF;
    step();
    vectors++;
    if (g_alu !== 1'b1 || bus.wb_en !== 1'b1 || bus.wb_rd !== 4'd3 || bus.wb_data !== 16'hBEEF || bus.wb_src !== 2'd1) begin
      miscompares++;
      $display("FAIL single_alu: en=%b rd=%0d data=%h src=%0d, expected 1 3 beef 1",
               bus.wb_en, bus.wb_rd, bus.wb_data, bus.wb_src);
    end
    idle_inputs();
    step();
    vectors++;
    if (bus.wb_en !== 1'b0 || bus.wb_rd !== 4'd3 || bus.wb_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL single_alu_idle: en=%b rd=%0d data=%h, expected 0 3 beef", bus.wb_en, bus.wb_rd, bus.wb_data);
    end
  endtask

  task automatic test_contention();
    logic [4:0] ld_seq, exp_seq;
    exp_seq = 5'b10111;  // bit i = load granted in cycle i: L L L A L
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 16'h0011;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd2; bus.ld_data  = 16'h0022;
    for (int i = 0; i < 5; i++) begin
      bus.ld_data = 16'h0022 + 16'(i);
      step();
      ld_seq[i] = g_ld;
    end
    vectors++;
    if (ld_seq !== exp_seq) begin
      miscompares++;
      $display("FAIL contention_order: got %b, expected %b", ld_seq, exp_seq);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_same_rd();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h0001;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd7; bus.ld_data  = 16'h0002;
    step();
    vectors++;
    if (bus.wb_src !== 2'd2 || bus.wb_data !== 16'h0002) begin
      miscompares++;
      $display("FAIL same_rd_first: src=%0d data=%h, expected 2 0002", bus.wb_src, bus.wb_data);
    end
    bus.ld_valid = 1'b0;
    step();
    idle_inputs();
    step();
    vectors++;
    if (dut_rf[7] !== 16'h0001) begin
      miscompares++;
      $display("FAIL same_rd_final: r7=%h, expected 0001", dut_rf[7]);
    end
  endtask

  task automatic test_sb_collision();
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd4;
    step();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd4; bus.alu_data = 16'h4444;
    step();
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd4;   // same cycle as wb_en/wb_rd=4
    step();
    idle_inputs();
    step();
    vectors++;
    if (bus.busy[4] !== 1'b1 || bus.waw_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_collision: busy4=%b waw=%b, expected 1 0", bus.busy[4], bus.waw_err);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd4; bus.alu_data = 16'h4445;
    step();
    bus.alu_rd = 4'd11;                       // write to a non-busy register
    step();
    idle_inputs();
    step();
    vectors++;
    if (bus.busy !== 16'h0 || bus.waw_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_clear: busy=%h waw=%b, expected 0000 0", bus.busy, bus.waw_err);
    end
  endtask

  task automatic test_waw();
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd9;
    step();
    step();
    idle_inputs();
    step();
    vectors++;
    if (bus.busy[9] !== 1'b1 || bus.waw_err !== 1'b1) begin
      miscompares++;
      $display("FAIL waw_set: busy9=%b waw=%b, expected 1 1", bus.busy[9], bus.waw_err);
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 4'd9; bus.ld_data = 16'h9999;
    step();
    idle_inputs();
    step();
    step();
    vectors++;
    if (bus.busy[9] !== 1'b0 || bus.waw_err !== 1'b1) begin
      miscompares++;
      $display("FAIL waw_sticky: busy9=%b waw=%b, expected 0 1", bus.busy[9], bus.waw_err);
    end
    do_reset();
    step();
    vectors++;
    if (bus.waw_err !== 1'b0) begin
      miscompares++;
      $display("FAIL waw_reset: waw=%b, expected 0", bus.waw_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      // Held requests stay stable until accepted, as producers must.
      if (!bus.alu_valid || g_alu) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 4'($urandom_range(0, 15));
        bus.alu_data  = 16'($urandom);
      end
      if (!bus.ld_valid || g_ld) begin
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_rd    = 4'($urandom_range(0, 15));
        bus.ld_data  = 16'($urandom);
      end
      bus.iss_valid = ($urandom_range(0, 3) == 0);
      bus.iss_rd    = 4'($urandom_range(0, 15));
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    g_alu = 1'b0; g_ld = 1'b0;
    for (int r = 0; r < NREG; r++) dut_rf[r] = '0;
    model_reset();
    test_reset();
    test_single_alu();
    test_contention();
    test_same_rd();
    test_sb_collision();
    test_waw();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
